alu_cmd_sequencer: RTL

Command sequencer wrapped around the team's combinational 4-bit ALU. Buffers incoming {A, B, opcode} commands in a small FIFO and issues them one at a time on registered operand lines. Captures the ALU's 8-bit {Zero, Carry, Sign, Error, result} word one cycle after issue and returns it with a wrapping sequence tag over a valid/ready handshake.

---
 rtl/alu_seq_pkg.sv | 35 +++
 rtl/alu_seq_fifo.sv | 45 ++++
 rtl/alu_cmd_sequencer.sv | 116 +++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer: FSM states,
// ALU flag bit positions and opcode encodings.
package alu_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      OUT   = 2'd2
   } seq_state_e;

   localparam int CMD_W = 12;

   localparam int FLG_Z = 7;
   localparam int FLG_C = 6;
   localparam int FLG_S = 5;
   localparam int FLG_E = 4;

   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_SUB = 4'h1;
   localparam logic [3:0] OP_MUL = 4'h2;
   localparam logic [3:0] OP_DIV = 4'h3;
   localparam logic [3:0] OP_MOD = 4'h4;
   localparam logic [3:0] OP_AND = 4'h5;
   localparam logic [3:0] OP_OR  = 4'h6;
   localparam logic [3:0] OP_XOR = 4'h7;
   localparam logic [3:0] OP_NOT = 4'h8;
   localparam logic [3:0] OP_SHL = 4'h9;
   localparam logic [3:0] OP_SHR = 4'hA;
   localparam logic [3:0] OP_ROL = 4'hB;
   localparam logic [3:0] OP_ROR = 4'hC;
   localparam logic [3:0] OP_LT  = 4'hD;
   localparam logic [3:0] OP_GT  = 4'hE;
   localparam logic [3:0] OP_EQ  = 4'hF;

endpackage

// File: rtl/alu_seq_fifo.sv
// DEPTH x W synchronous FIFO with wrap-bit pointers; push is ignored when
// full and pop when empty, so there is no pass-through on a full FIFO.
module alu_seq_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 12
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr, rd_ptr;
   logic         do_push, do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Same index with opposite wrap bits means the writer lapped the reader.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rdata = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issues buffered {A,B,op} commands to an external combinational ALU one at a
// time and returns each tagged result over valid/ready. ALU_SEQ_ERRCNT_EN
// enables the saturating error counter; otherwise err_count is tied to zero.
module alu_cmd_sequencer
   import alu_seq_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_a,
   input  logic [3:0]       cmd_b,
   input  logic [3:0]       cmd_op,
   output logic [3:0]       alu_a,
   output logic [3:0]       alu_b,
   output logic [3:0]       alu_op,
   input  logic [7:0]       alu_res,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [7:0]       res_data,
   output logic [TAG_W-1:0] res_tag,
   output logic             busy,
   output logic [7:0]       err_count
);

   seq_state_e       state, state_nxt;
   logic [CMD_W-1:0] head;
   logic             full, empty;
   logic             load, cap, hs;
   logic [TAG_W-1:0] tag_cnt;

   alu_seq_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (cmd_valid),
      .pop   (cap),
      .wdata ({cmd_a, cmd_b, cmd_op}),
      .rdata (head),
      .full  (full),
      .empty (empty)
   );

   assign cmd_ready = !full;
   assign busy      = !empty || (state != IDLE);

   // The issued command stays at the FIFO head until its result is captured.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      cap       = 1'b0;
      hs        = 1'b0;
      unique case (state)
         IDLE: begin
            if (!empty) begin
               load      = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            cap       = 1'b1;
            state_nxt = OUT;
         end
         OUT: begin
            if (res_ready) begin
               hs        = 1'b1;
               load      = !empty;
               state_nxt = empty ? IDLE : ISSUE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_op    <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_tag   <= '0;
         tag_cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (load) {alu_a, alu_b, alu_op} <= head;
         if (cap) begin
            res_data  <= alu_res;
            res_tag   <= tag_cnt;
            res_valid <= 1'b1;
            tag_cnt   <= tag_cnt + TAG_W'(1);
         end else if (hs) begin
            res_valid <= 1'b0;
         end
      end
   end

`ifdef ALU_SEQ_ERRCNT_EN
   logic [7:0] err_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         err_cnt <= '0;
      else if (cap && alu_res[FLG_E] && (err_cnt != 8'hFF))
         err_cnt <= err_cnt + 8'd1;
   end

   assign err_count = err_cnt;
`else
   assign err_count = 8'h00;
`endif

endmodule
